imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 177 +++++++++++++++++
 tb/tb_imm_decode_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: extracts and extends the RISC-V immediate,
// classifies its format, and registers the result with a 1- or 2-entry output buffer.
module imm_decode_stage #(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_I    = 3'd1,
    T_S    = 3'd2,
    T_B    = 3'd3,
    T_U    = 3'd4,
    T_J    = 3'd5,
    T_Z    = 3'd6
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_type_e       typ;
    logic            ill;
    logic [XLEN-1:0] pc;
  } entry_t;

  localparam bit IS64 = (XLEN == 64);

  imm_type_e       dec_type;
  logic            dec_ill;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  entry_t          dec_entry;

  // funct3[1:0] never influences the immediate or the format.
  logic unused_bits;
  assign unused_bits = &{1'b0, in_instr[13:12]};

  always_comb begin
    dec_type = T_NONE;
    dec_ill  = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      case (in_instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: dec_type = T_I;
        7'b0011011: begin
          if (IS64) dec_type = T_I;
          else      dec_ill  = 1'b1;
        end
        7'b0100011:             dec_type = T_S;
        7'b1100011:             dec_type = T_B;
        7'b0110111, 7'b0010111: dec_type = T_U;
        7'b1101111:             dec_type = T_J;
        7'b1110011: begin
          if (in_instr[14]) dec_type = T_Z;
        end
        7'b0110011, 7'b0001111: dec_type = T_NONE;
        7'b0111011: begin
          if (!IS64) dec_ill = 1'b1;
        end
        default: dec_ill = 1'b1;
      endcase
    end

    // Every format is first formed as a 32-bit value; Z has bit 31 clear so the
    // widening step below zero-extends it while sign-extending the others.
    case (dec_type)
      T_I:     dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      T_S:     dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      T_B:     dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
      T_U:     dec_imm32 = {in_instr[31:12], 12'b0};
      T_J:     dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
      T_Z:     dec_imm32 = {27'b0, in_instr[19:15]};
      default: dec_imm32 = '0;
    endcase

    dec_imm        = {XLEN{dec_imm32[31]}};
    dec_imm[31:0]  = dec_imm32;

    dec_entry.imm  = dec_imm;
    dec_entry.typ  = dec_type;
    dec_entry.ill  = dec_ill;
    dec_entry.pc   = in_pc;
  end

  // Handshake: a transfer happens on an edge where valid && ready are both high;
  // out_ready is don't-care while out_valid is low, and a valid output holds
  // stable until it is consumed.
  entry_t prim_q, prim_d, skid_q, skid_d;
  logic   prim_valid_q, prim_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   rdy_q, rdy_d;
  logic   accept, consume;

  assign accept  = in_valid && in_ready;
  assign consume = prim_valid_q && out_ready;

  always_comb begin
    if (SKID) in_ready = rdy_q && !rst;
    else      in_ready = !rst && (!prim_valid_q || out_ready);
  end

  always_comb begin
    prim_d       = prim_q;
    skid_d       = skid_q;
    prim_valid_d = prim_valid_q;
    skid_valid_d = skid_valid_q;
    if (SKID) begin
      if (consume) begin
        if (skid_valid_q) begin
          prim_d = skid_q;
          if (accept) skid_d = dec_entry;
          else        skid_valid_d = 1'b0;
        end else if (accept) begin
          prim_d = dec_entry;
        end else begin
          prim_valid_d = 1'b0;
        end
      end else if (accept) begin
        // The skid entry is only ever filled while the primary is stalled.
        if (prim_valid_q) begin
          skid_d       = dec_entry;
          skid_valid_d = 1'b1;
        end else begin
          prim_d       = dec_entry;
          prim_valid_d = 1'b1;
        end
      end
    end else begin
      skid_valid_d = 1'b0;
      if (accept) begin
        prim_d       = dec_entry;
        prim_valid_d = 1'b1;
      end else if (consume) begin
        prim_valid_d = 1'b0;
      end
    end
    rdy_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prim_q       <= '0;
      skid_q       <= '0;
      prim_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b1;
    end else begin
      prim_q       <= prim_d;
      skid_q       <= skid_d;
      prim_valid_q <= prim_valid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= rdy_d;
    end
  end

  assign out_valid   = prim_valid_q;
  assign out_imm     = prim_q.imm;
  assign out_type    = prim_q.typ;
  assign out_illegal = prim_q.ill;
  assign out_pc      = prim_q.pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: XLEN=32/SKID=1 and XLEN=64/SKID=0 instances.
module tb_imm_decode_stage;

  logic        clk;
  logic        rst;
  int          n_cmp;
  int          n_err;

  logic        v32, rdy32, ovalid32, ordy32, oill32;
  logic [31:0] instr32, pc32, oimm32, opc32;
  logic [2:0]  otype32;

  logic        v64, rdy64, ovalid64, ordy64, oill64;
  logic [31:0] instr64;
  logic [63:0] pc64, oimm64, opc64;
  logic [2:0]  otype64;

  imm_decode_stage #(.XLEN(32), .SKID(1'b1)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(v32), .in_ready(rdy32), .in_instr(instr32), .in_pc(pc32),
    .out_valid(ovalid32), .out_ready(ordy32), .out_imm(oimm32),
    .out_type(otype32), .out_illegal(oill32), .out_pc(opc32)
  );

  imm_decode_stage #(.XLEN(64), .SKID(1'b0)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(v64), .in_ready(rdy64), .in_instr(instr64), .in_pc(pc64),
    .out_valid(ovalid64), .out_ready(ordy64), .out_imm(oimm64),
    .out_type(otype64), .out_illegal(oill64), .out_pc(opc64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-decoded vectors for the 32-bit instance.
  logic [31:0] t32_instr [15] = '{
    32'hFFF00093, 32'hFE000EE3, 32'h300FD073, 32'h0000007F, 32'hFFF00091,
    32'hFE112E23, 32'h12345097, 32'h0080006F, 32'h002081B3, 32'h0000000F,
    32'h30001073, 32'hFFF0009B, 32'h800002B7, 32'h00812083, 32'hFFC08067};
  logic [31:0] t32_imm [15] = '{
    32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0000001F, 32'h0, 32'h0,
    32'hFFFFFFFC, 32'h12345000, 32'h00000008, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h80000000, 32'h00000008, 32'hFFFFFFFC};
  logic [2:0] t32_type [15] = '{
    3'd1, 3'd3, 3'd6, 3'd0, 3'd0, 3'd2, 3'd4, 3'd5, 3'd0, 3'd0,
    3'd0, 3'd0, 3'd4, 3'd1, 3'd1};
  logic t32_ill [15] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  logic [31:0] t64_instr [8] = '{
    32'h800002B7, 32'hFFF0009B, 32'h0000003B, 32'hFE000EE3,
    32'h300FD073, 32'h0000007F, 32'h12345097, 32'hFFDFF06F};
  logic [63:0] t64_imm [8] = '{
    64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFC,
    64'h000000000000001F, 64'h0, 64'h0000000012345000, 64'hFFFFFFFFFFFFFFFC};
  logic [2:0] t64_type [8] = '{3'd4, 3'd1, 3'd0, 3'd3, 3'd6, 3'd0, 3'd4, 3'd5};
  logic t64_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic v, input logic [31:0] imm,
                       input logic [2:0] typ, input logic ill, input logic [31:0] pc);
    chk({tag, ".valid"}, {63'b0, ovalid32}, {63'b0, v});
    chk({tag, ".imm"},   {32'b0, oimm32},   {32'b0, imm});
    chk({tag, ".type"},  {61'b0, otype32},  {61'b0, typ});
    chk({tag, ".ill"},   {63'b0, oill32},   {63'b0, ill});
    chk({tag, ".pc"},    {32'b0, opc32},    {32'b0, pc});
  endtask

  task automatic chk64(input string tag, input logic v, input logic [63:0] imm,
                       input logic [2:0] typ, input logic ill, input logic [63:0] pc);
    chk({tag, ".valid"}, {63'b0, ovalid64}, {63'b0, v});
    chk({tag, ".imm"},   oimm64,            imm);
    chk({tag, ".type"},  {61'b0, otype64},  {61'b0, typ});
    chk({tag, ".ill"},   {63'b0, oill64},   {63'b0, ill});
    chk({tag, ".pc"},    opc64,             pc);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    v32 = 1'b0; instr32 = '0; pc32 = '0; ordy32 = 1'b0;
    v64 = 1'b0; instr64 = '0; pc64 = '0; ordy64 = 1'b0;

    // Reset state, sampled while rst is still high.
    tick();
    tick();
    chk32("rst32", 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    chk("rst32.in_ready", {63'b0, rdy32}, 64'h0);
    chk64("rst64", 1'b0, 64'h0, 3'd0, 1'b0, 64'h0);
    chk("rst64.in_ready", {63'b0, rdy64}, 64'h0);

    rst = 1'b0;
    #1;
    chk("rel32.in_ready", {63'b0, rdy32}, 64'h1);
    chk("rel64.in_ready", {63'b0, rdy64}, 64'h1);

    // Back-to-back stream at full throughput through the 32-bit skid instance.
    ordy32 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      v32 = 1'b1;
      instr32 = t32_instr[i];
      pc32 = 32'h100 + 32'(4 * i);
      #1;
      chk($sformatf("s32[%0d].in_ready", i), {63'b0, rdy32}, 64'h1);
      tick();
      chk32($sformatf("s32[%0d]", i), 1'b1, t32_imm[i], t32_type[i], t32_ill[i],
            32'h100 + 32'(4 * i));
    end
    v32 = 1'b0;
    tick();
    chk("drain32.valid", {63'b0, ovalid32}, 64'h0);

    // Backpressure: A and B are taken, C is refused until the primary drains.
    ordy32 = 1'b0;
    v32 = 1'b1; instr32 = 32'h00500093; pc32 = 32'h200;
    #1;
    chk("bpA.in_ready", {63'b0, rdy32}, 64'h1);
    tick();
    chk32("bpA", 1'b1, 32'h5, 3'd1, 1'b0, 32'h200);
    instr32 = 32'h00600093; pc32 = 32'h204;
    #1;
    chk("bpB.in_ready", {63'b0, rdy32}, 64'h1);
    tick();
    chk32("bpA.hold1", 1'b1, 32'h5, 3'd1, 1'b0, 32'h200);
    instr32 = 32'h00700093; pc32 = 32'h208;
    #1;
    chk("bpC.in_ready", {63'b0, rdy32}, 64'h0);
    tick();
    chk32("bpA.hold2", 1'b1, 32'h5, 3'd1, 1'b0, 32'h200);
    chk("bpC.still_blocked", {63'b0, rdy32}, 64'h0);
    ordy32 = 1'b1;
    tick();
    chk32("bpB", 1'b1, 32'h6, 3'd1, 1'b0, 32'h204);
    chk("bpC.in_ready_after", {63'b0, rdy32}, 64'h1);
    tick();
    chk32("bpC", 1'b1, 32'h7, 3'd1, 1'b0, 32'h208);
    v32 = 1'b0;
    tick();
    chk("bp.drain", {63'b0, ovalid32}, 64'h0);

    // Reset while both entries are occupied.
    ordy32 = 1'b0;
    v32 = 1'b1; instr32 = 32'h00800093; pc32 = 32'h300;
    tick();
    instr32 = 32'h00900093; pc32 = 32'h304;
    tick();
    chk("full.in_ready", {63'b0, rdy32}, 64'h0);
    v32 = 1'b0;
    rst = 1'b1;
    ordy32 = 1'b1;
    tick();
    chk32("mrst", 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    chk("mrst.in_ready", {63'b0, rdy32}, 64'h0);
    rst = 1'b0;
    #1;
    chk("mrst.rel_ready", {63'b0, rdy32}, 64'h1);
    tick();
    chk("mrst.no_stale1", {63'b0, ovalid32}, 64'h0);
    tick();
    chk("mrst.no_stale2", {63'b0, ovalid32}, 64'h0);

    // 64-bit, single-register instance.
    ordy64 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v64 = 1'b1;
      instr64 = t64_instr[i];
      pc64 = 64'h8000_0000_0000_1000 + 64'(8 * i);
      tick();
      chk64($sformatf("s64[%0d]", i), 1'b1, t64_imm[i], t64_type[i], t64_ill[i],
            64'h8000_0000_0000_1000 + 64'(8 * i));
    end
    v64 = 1'b0;
    tick();
    chk("drain64.valid", {63'b0, ovalid64}, 64'h0);

    ordy64 = 1'b0;
    v64 = 1'b1; instr64 = 32'h00500093; pc64 = 64'h40;
    tick();
    chk64("bp64X", 1'b1, 64'h5, 3'd1, 1'b0, 64'h40);
    chk("bp64.in_ready", {63'b0, rdy64}, 64'h0);
    instr64 = 32'h00600093; pc64 = 64'h44;
    tick();
    chk64("bp64X.hold", 1'b1, 64'h5, 3'd1, 1'b0, 64'h40);
    ordy64 = 1'b1;
    #1;
    chk("bp64.in_ready_comb", {63'b0, rdy64}, 64'h1);
    tick();
    chk64("bp64Y", 1'b1, 64'h6, 3'd1, 1'b0, 64'h44);
    v64 = 1'b0;
    tick();
    chk("bp64.drain", {63'b0, ovalid64}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
